imm_extend_unit: RTL
====================

Name: imm_extend_unit

Overview:
- Registered, parametrised immediate generator for the 16-bit datapath, sitting between decode and the ALU operand mux.
- Takes the split immediate field from decode in two halves. Produces a DATA_W operand by sign extension, zero extension or upper-load placement.
- Can optionally glue a preceding prefix instruction's immediate onto the next immediate.
- Uses a valid/ready handshake with one output register stage. Supports flush on a pipeline redirect.

Parameters:
- DATA_W, 16, output operand width. Constraint: IMM_W < DATA_W <= 2*IMM_W.
- IMM_W, 8, raw immediate width. Must be even; it is split into two halves of IMM_W/2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- flush  input  1  synchronous pipeline flush.
- in_valid  input  1  decode presents an immediate.
- in_ready  output  1  unit accepts the immediate this cycle.
- mode  input  2  00 SEXT, 01 ZEXT, 10 LUI, 11 PREFIX.
- imm_upper  input  IMM_W/2  upper half of the immediate.
- imm_lower  input  IMM_W/2  lower half of the immediate.
- out_valid  output  1  imm_out holds a result.
- out_ready  input  1  consumer takes the result.
- imm_out  output  DATA_W  extended immediate.
- pfx_pending  output  1  a prefix is held, waiting for its consumer.

Behaviour:
- Reset (reset=0, async): out_valid=0, imm_out=0, pfx_pending=0, prefix register=0, FSM=IDLE. On release, the first accept can occur on the first clk edge.
- in_ready = !flush && (!out_valid || out_ready). This is combinational. A transfer occurs on in_valid && in_ready at a rising edge.
- Latency: an accepted non-prefix input appears on imm_out with out_valid=1 at the next edge (1 cycle).
- Backpressure: while out_valid && !out_ready, imm_out and out_valid hold stable. Accept plus out_ready in the same cycle gives back-to-back throughput of 1 per clock.
- Let imm = {imm_upper, imm_lower} and P = DATA_W - IMM_W.
- SEXT: imm_out = {P copies of imm[IMM_W-1], imm}.
- ZEXT: imm_out = {P zeros, imm}.
- LUI: imm_out = imm << P, truncated to DATA_W (low P bits are zero).
- FSM, with IMM_PREFIX_EN defined:
  - IDLE --accepted PREFIX--> PFX. Latch prefix register = imm[P-1:0]. No output is produced; out_valid is unaffected.
  - PFX --accepted SEXT or ZEXT--> IDLE. imm_out = {prefix register, imm}; the extension kind is irrelevant because all bits are explicit.
  - PFX --accepted LUI--> IDLE. The prefix is discarded and imm_out follows the normal LUI rule.
  - PFX --accepted PREFIX--> PFX. The prefix register is overwritten (last prefix wins).
  - pfx_pending = (FSM == PFX).
- Flush (synchronous, highest priority):
  - Clears out_valid and returns the FSM to IDLE (pfx_pending=0).
  - Forces in_ready=0, so a same-cycle input is dropped.
  - imm_out keeps its last value; it is don't-care while out_valid=0.
- Reset asserted mid-operation: all state is cleared immediately (async). A held result or prefix is lost with no partial output.
- A simultaneous out_ready and flush clears out_valid (the consumer must not have sampled a result it relies on after a flush).

Optional Feature:
- Macro: IMM_PREFIX_EN.
- Defined: PREFIX mode, the FSM and the prefix register exist as described above.
- Undefined: there is no FSM or prefix register. mode=11 is treated exactly as SEXT and pfx_pending is tied 0.

Test Plan:
- Reset held low, then released; SEXT imm_upper=0x8, imm_lower=0x0 with out_ready=1 -> next cycle out_valid=1, imm_out=0xFF80.
- ZEXT 0x80 -> 0x0080. LUI 0x12 -> 0x1200. SEXT 0x7F -> 0x007F. Issue back-to-back with out_ready=1 -> one result per cycle, in order.
- IMM_PREFIX_EN: PREFIX 0xAB, then SEXT 0xCD -> pfx_pending=1 between them, then imm_out=0xABCD, pfx_pending=0. PREFIX 0x11, PREFIX 0x22, ZEXT 0x33 -> 0x2233. PREFIX 0xAB, then LUI 0x12 -> 0x1200.
- Backpressure: SEXT 0x80 accepted with out_ready=0 for 3 cycles -> imm_out stays 0xFF80, in_ready=0, and a second input is held off. Then out_ready=1 -> the second result follows on the next cycle.
- Flush: PREFIX 0xAB accepted, then flush=1 with in_valid SEXT 0xCD -> in_ready=0 and the input is dropped. Next SEXT 0xCD -> 0xFFCD (prefix gone).
- Reset low asynchronously mid-cycle while out_valid=1 and pfx_pending=1 -> both drop to 0 before the next edge, and imm_out=0.

Source files
------------

// File: rtl/imm_extend_unit.sv
// Registered immediate generator: SEXT / ZEXT / LUI with one output stage.
// Optional prefix glue when IMM_PREFIX_EN is defined.
//
// Ports:
//   clk, reset (async, active-low), flush (sync, highest priority)
//   in_valid/in_ready, mode, imm_upper, imm_lower  : decode side
//   out_valid/out_ready, imm_out                    : ALU operand side
//   pfx_pending                                     : a prefix is held
module imm_extend_unit #(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           mode,
    input  logic [IMM_W/2-1:0]   imm_upper,
    input  logic [IMM_W/2-1:0]   imm_lower,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    imm_out,
    output logic                 pfx_pending
);

    localparam int P = DATA_W - IMM_W;

    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] sext_v;
    logic [DATA_W-1:0] zext_v;
    logic [DATA_W-1:0] lui_v;
    logic [DATA_W-1:0] res;
    logic              accept;
    logic              produce;

    assign imm      = {imm_upper, imm_lower};
    assign sext_v   = {{P{imm[IMM_W-1]}}, imm};
    assign zext_v   = {{P{1'b0}}, imm};
    assign lui_v    = {imm, {P{1'b0}}};
    assign in_ready = !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

`ifdef IMM_PREFIX_EN
    typedef enum logic {IDLE, PFX} state_t;

    state_t       state;
    state_t       nxt_state;
    logic [P-1:0] pfx_q;
    logic         pfx_ld;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            pfx_q <= '0;
        end else begin
            state <= nxt_state;
            if (pfx_ld) pfx_q <= imm[P-1:0];
        end
    end

    assign pfx_pending = (state == PFX);

    always_comb begin
        res       = sext_v;
        produce   = accept;
        nxt_state = state;
        pfx_ld    = 1'b0;
        unique case (mode)
            2'b01:   res = zext_v;
            2'b10:   res = lui_v;
            default: res = sext_v;
        endcase
        // A held prefix supplies the upper bits explicitly for SEXT/ZEXT;
        // LUI ignores it and follows its own placement.
        if (state == PFX && !mode[1]) res = {pfx_q, imm};
        if (accept) begin
            if (mode == 2'b11) begin
                produce   = 1'b0;
                pfx_ld    = 1'b1;
                nxt_state = PFX;
            end else begin
                nxt_state = IDLE;
            end
        end
        if (flush) nxt_state = IDLE;
    end
`else
    assign pfx_pending = 1'b0;

    // mode 11 falls through to SEXT when prefixing is compiled out.
    always_comb begin
        res     = sext_v;
        produce = accept;
        unique case (mode)
            2'b01:   res = zext_v;
            2'b10:   res = lui_v;
            default: res = sext_v;
        endcase
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            imm_out   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (produce) begin
            out_valid <= 1'b1;
            imm_out   <= res;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
